// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared systolic array types and constants
package systolic_pkg;

  // Byte lanes feeding the downstream skew buffer.
  localparam int LANES = 4;

  // Zero words appended after the data so the deepest skew lane drains.
  localparam int FLUSH_N_DEFAULT = LANES - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/input_feeder.sv
// rtl/input_feeder.sv - streams K SRAM words plus zero flush words to the skew buffer
module input_feeder
  import systolic_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int FLUSH_N = FLUSH_N_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] k_len,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  // FLUSH lasts FLUSH_N word slots plus two drain cycles for the read pipeline.
  localparam logic [ADDR_W-1:0] FLUSH_WORDS = ADDR_W'(FLUSH_N);
  localparam logic [ADDR_W-1:0] FLUSH_LAST  = ADDR_W'(FLUSH_N + 1);

  feeder_state_e     state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] len_q;
  logic              rd_valid;
  logic              rd_zero;
  logic              flush_word;

  // A flush slot behaves like a read whose data is forced to zero.
  assign flush_word = (state == FLUSH) && (cnt < FLUSH_WORDS);

  // Control FSM: issues reads, times the flush/drain, and owns busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      sram_en   <= 1'b0;
      sram_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state     <= IDLE;
          cnt       <= '0;
          sram_en   <= 1'b0;
          sram_addr <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            len_q <= k_len;
            busy  <= 1'b1;
            if (k_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= READ;
              sram_en   <= 1'b1;
              sram_addr <= base_addr;
              cnt       <= ADDR_W'(1);
            end
          end
        end
        READ: begin
          if (cnt == len_q) begin
            state     <= FLUSH;
            cnt       <= '0;
            sram_en   <= 1'b0;
            sram_addr <= '0;
          end else begin
            cnt       <= cnt + ADDR_W'(1);
            sram_addr <= sram_addr + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state <= DONE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          sram_en   <= 1'b0;
          sram_addr <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage output pipeline: track the SRAM latency, then register the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_zero   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_valid  <= sram_en | flush_word;
      rd_zero   <= flush_word;
      out_valid <= rd_valid;
      out_data  <= (rd_valid && !rd_zero) ? sram_rdata : '0;
    end
  end

endmodule

// File: doc/input_feeder.md
INPUT_FEEDER -- requirements
Module: input_feeder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width (4 byte lanes feeding the downstream skew buffer).
REQ-003 SHALL have parameter FLUSH_N, default 3, meaning zero words appended after the data (lanes-1).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request a new transfer; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_W  first SRAM word address; captured when start is accepted.
REQ-008 SHALL have port k_len  input  ADDR_W  number of words to read; captured when start is accepted.
REQ-009 SHALL have port sram_en  output  1  SRAM read enable.
REQ-010 SHALL have port sram_addr  output  ADDR_W  SRAM read address.
REQ-011 SHALL have port sram_rdata  input  DATA_W  SRAM read data, valid one cycle after sram_en.
REQ-012 SHALL have port out_data  output  DATA_W  word stream to the skew buffer's in_data.
REQ-013 SHALL have port out_valid  output  1  out_data carries a data or flush word.
REQ-014 SHALL have port busy  output  1  transfer in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, READ, FLUSH, DONE; reset state IDLE.
REQ-017 SHALL accept start only in IDLE; start in any other state is ignored, with no effect on the running transfer.
REQ-018 With start accepted at the edge ending cycle 0 and K=k_len>0, SHALL drive sram_en=1 in cycles 1..K with sram_addr=base_addr+i (i=0..K-1), modulo 2^ADDR_W (wrap from all-ones to 0).
REQ-019 SHALL register sram_rdata, so word i appears on out_data with out_valid=1 in cycle i+3 (cycles 3..K+2), with no gaps.
REQ-020 SHALL output FLUSH_N all-zero words with out_valid=1 in cycles K+3..K+2+FLUSH_N, contiguous with the data words.
REQ-021 SHALL assert done for exactly cycle K+3+FLUSH_N, then return to IDLE; a new start SHALL be accepted in that same cycle.
REQ-022 SHALL hold busy=1 in cycles 1 through the done cycle inclusive, and 0 otherwise.
REQ-023 SHALL hold out_data=0 whenever out_valid=0; sram_addr=0 whenever sram_en=0.
REQ-024 With k_len=0, SHALL issue no reads and no flush words, and SHALL pulse done in cycle 1 with busy=1 in that cycle only.
REQ-025 SHALL be unaffected by changes to base_addr/k_len after acceptance (captured copies used).

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE and sram_en, sram_addr, out_data, out_valid, busy, done and all counters to 0, including mid-READ or mid-FLUSH; no pending word SHALL be emitted after reset release.
REQ-027 After rst_n rises, the first start SHALL behave exactly per REQ-018..REQ-022.

Structure
REQ-028 The FSM state enum and the FLUSH_N default SHALL live in the shared systolic package, alongside the lane count.
REQ-029 SHALL be a single flat module with no sub-module; the downstream skew buffer is instantiated by the parent, not here.

Verification
REQ-030 base=0x0010, K=4, SRAM[0x10..0x13]=ABCD1234,12345678,FEDCBA98,11223344 -> those words on out_data in cycles 3-6, zeros with valid in cycles 7-9, done in cycle 10; the chained skew buffer output in cycle 6 equals 11DC5634.
REQ-031 K=0 -> sram_en never high, out_valid never high, done in cycle 1.
REQ-032 base=0xFFFE, K=4 -> sram_addr sequence FFFE, FFFF, 0000, 0001.
REQ-033 start re-pulsed in cycles 2 and 5 of a K=4 transfer -> waveform identical to REQ-030; back-to-back start in the done cycle -> next sram_en in the following cycle.
REQ-034 rst_n low in cycle 4 of a K=8 transfer -> all outputs 0 immediately; after release, no stray valid; a new K=2 transfer completes with done in cycle 8.
